serial_adder: RTL and testbench



---
 rtl/serial_adder_if.sv | 23 ++
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - start/operand/result bundle for the bit-serial adder
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (
    output start, a, b, c_in,
    input  busy, done, sum, c_out
  );

  modport slave (
    input  start, a, b, c_in,
    output busy, done, sum, c_out
  );
endinterface

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder: one full-adder cell plus carry flop, LSB first
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  serial_adder_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_sr_q, a_sr_d;
  logic [WIDTH-1:0]   b_sr_q, b_sr_d;
  logic               carry_q, carry_d;
  logic [WIDTH-2:0]   ps_q, ps_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_co;
  logic [WIDTH-1:0]   ps_cat;

  always_comb begin
    fa_s  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    fa_co = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
  end

  // The newest cell output enters at the top; after WIDTH shifts bit 0 sits at the bottom.
  assign ps_cat = {fa_s, ps_q};

  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    carry_d = carry_q;
    ps_d    = ps_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_sr_d  = bus.a;
          b_sr_d  = bus.b;
          carry_d = bus.c_in;
          ps_d    = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sr_d  = a_sr_q >> 1;
        b_sr_d  = b_sr_q >> 1;
        carry_d = fa_co;
        ps_d    = ps_cat[WIDTH-1:1];
        if (cnt_q == CNT_LAST) begin
          sum_d   = ps_cat;
          c_out_d = fa_co;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      carry_q <= 1'b0;
      ps_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      carry_q <= carry_d;
      ps_q    <= ps_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - randomized self-checking bench for serial_adder at WIDTH 8 and 16
module tb_serial_adder;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  serial_adder_if #(.WIDTH(8))  bus8 ();
  serial_adder_if #(.WIDTH(16)) bus16 ();

  serial_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {c_out, sum} is the plain integer sum of the masked operands and carry-in.
  function automatic logic [16:0] model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                        input logic cv);
    int unsigned m;
    int unsigned t;
    m = (1 << w) - 1;
    t = (av & m) + (bv & m) + cv;
    return {(t >> w) & 1'b1 ? 1'b1 : 1'b0, 16'(t & m)};
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv);
    if (w == 8) begin
      bus8.start = st; bus8.a = av[7:0]; bus8.b = bv[7:0]; bus8.c_in = cv;
    end else begin
      bus16.start = st; bus16.a = av; bus16.b = bv; bus16.c_in = cv;
    end
  endtask

  task automatic sample(input int w, output logic bz, output logic dn, output logic [15:0] s,
                        output logic co);
    if (w == 8) begin
      bz = bus8.busy; dn = bus8.done; s = {8'h00, bus8.sum}; co = bus8.c_out;
    end else begin
      bz = bus16.busy; dn = bus16.done; s = bus16.sum; co = bus16.c_out;
    end
  endtask

  // Called at a negedge; starts immediately and returns at the negedge of the done cycle.
  task automatic do_op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic cv,
                       output logic [15:0] s, output logic co, output int lat,
                       output int busy_n, output bit clean);
    logic bz, dn, pco;
    logic [15:0] ps;
    sample(w, bz, dn, ps, pco);
    drive(w, 1'b1, av, bv, cv);
    @(negedge clk);
    lat = 1; busy_n = 0; clean = 1'b1;
    drive(w, 1'b0, ~av, ~bv, ~cv);
    for (int k = 0; k < 64; k++) begin
      sample(w, bz, dn, s, co);
      if (bz && dn) clean = 1'b0;
      if (bz) busy_n++;
      if (dn) break;
      if (s !== ps || co !== pco) clean = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(8, 1'b1, 16'h0055, 16'h00AA, 1'b1);
    drive(16, 1'b1, 16'h1234, 16'h4321, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++;
      if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.c_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset8 cycle %0d: busy=%b done=%b sum=%h c_out=%b, want 0 0 00 0",
                 i, bus8.busy, bus8.done, bus8.sum, bus8.c_out);
      end
      n_tests++;
      if (bus16.busy !== 1'b0 || bus16.done !== 1'b0 || bus16.sum !== 16'h0 || bus16.c_out !== 1'b0) begin
        n_fail++;
        $display("FAIL reset16 cycle %0d: busy=%b done=%b sum=%h c_out=%b, want 0 0 0000 0",
                 i, bus16.busy, bus16.done, bus16.sum, bus16.c_out);
      end
    end
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus8.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: busy=%b, want 0", bus8.busy);
    end
  endtask

  task automatic test_directed;
    logic [15:0] av[3], bv[3], es[3];
    logic        cv[3], ec[3];
    logic [15:0] s;
    logic co;
    int lat, bn;
    bit cl;
    av = '{16'h00, 16'hFF, 16'hA5}; bv = '{16'h00, 16'h01, 16'h5A};
    cv = '{1'b1, 1'b0, 1'b1};
    es = '{16'h01, 16'h00, 16'h00}; ec = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(8, av[i], bv[i], cv[i], s, co, lat, bn, cl);
      n_tests++;
      if (s !== es[i] || co !== ec[i]) begin
        n_fail++;
        $display("FAIL directed%0d result: sum=%h c_out=%b, want %h %b", i, s, co, es[i], ec[i]);
      end
      n_tests++;
      if (lat !== 9 || bn !== 8 || !cl) begin
        n_fail++;
        $display("FAIL directed%0d timing: latency=%0d busy_cycles=%0d clean=%0d, want 9 8 1",
                 i, lat, bn, cl);
      end
    end
  endtask

  task automatic test_back_to_back;
    int cyc, first_done, second_done;
    logic [7:0] s1, s2;
    first_done = -1; second_done = -1;
    s1 = 8'hxx; s2 = 8'hxx;
    bus8.start = 1'b1; bus8.a = 8'h03; bus8.b = 8'h04; bus8.c_in = 1'b0;
    cyc = 0;
    for (int k = 0; k < 40 && second_done < 0; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        bus8.a = 8'h10; bus8.b = 8'h20;
      end
      if (bus8.done) begin
        if (first_done < 0) begin
          first_done = cyc; s1 = bus8.sum;
        end else begin
          second_done = cyc; s2 = bus8.sum;
          bus8.start = 1'b0;
        end
      end
    end
    bus8.start = 1'b0;
    n_tests++;
    if (first_done !== 9 || s1 !== 8'h07) begin
      n_fail++;
      $display("FAIL b2b_first: done_cycle=%0d sum=%h, want 9 07", first_done, s1);
    end
    n_tests++;
    if (second_done !== 18 || s2 !== 8'h30) begin
      n_fail++;
      $display("FAIL b2b_second: done_cycle=%0d sum=%h, want 18 30", second_done, s2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int dones;
    logic [15:0] s;
    logic co;
    int lat, bn;
    bit cl;
    drive(8, 1'b1, 16'hFF, 16'hFF, 1'b1);
    @(negedge clk);
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus8.sum !== 8'h00 || bus8.c_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: busy=%b done=%b sum=%h c_out=%b, want 0 0 00 0",
               bus8.busy, bus8.done, bus8.sum, bus8.c_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) dones++;
    end
    n_tests++;
    if (dones !== 0 || bus8.sum !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: activity_cycles=%0d sum=%h, want 0 00", dones, bus8.sum);
    end
    do_op(8, 16'h7E, 16'h83, 1'b1, s, co, lat, bn, cl);
    n_tests++;
    if (s !== 16'h02 || co !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("FAIL reset_mid_fresh: sum=%h c_out=%b latency=%0d, want 02 1 9", s, co, lat);
    end
  endtask

  task automatic test_random(input int w, input int n);
    logic [15:0] av, bv, s;
    logic [16:0] exp_v;
    logic cv, co;
    int lat, bn;
    bit cl;
    for (int i = 0; i < n; i++) begin
      av = 16'($urandom);
      bv = 16'($urandom);
      cv = 1'($urandom);
      if ($urandom_range(0, 9) == 0) av = 16'hFFFF;
      if ($urandom_range(0, 9) == 0) bv = 16'hFFFF;
      exp_v = model(w, av, bv, cv);
      do_op(w, av, bv, cv, s, co, lat, bn, cl);
      n_tests++;
      if ({co, s} !== exp_v || lat !== w + 1 || bn !== w || !cl) begin
        n_fail++;
        $display("FAIL random%0d #%0d a=%h b=%h c=%b: got c_out=%b sum=%h lat=%0d busy=%0d clean=%0d, want c_out=%b sum=%h lat=%0d busy=%0d clean=1",
                 w, i, av, bv, cv, co, s, lat, bn, cl, exp_v[16], exp_v[15:0], w + 1, w);
      end
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(8, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(16, 1'b0, 16'h0, 16'h0, 1'b0);
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_mid;
    test_random(8, 500);
    test_random(16, 500);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
